// File: rtl/boid_xcel_seq.sv
// Frame sequencer for the boid accelerator: walks every self/neighbour pair,
// NUM_LANES self boids at a time, using req/valid memory reads and a wb_en/wb_ready handshake.
module boid_xcel_seq #(
    parameter int              NUM_BOIDS = 8,
    parameter int              NUM_LANES = 2,
    parameter int              WB_W      = 7,
    parameter logic [WB_W-1:0] WB_MASK   = 7'b0011111,
    localparam int             IDX_W     = (NUM_BOIDS > 2) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 mem_req,
    output logic [IDX_W-1:0]     mem_idx,
    input  logic                 mem_valid,
    output logic [IDX_W-1:0]     self_base,
    output logic                 r_en_tot,
    output logic                 r_en_itr,
    output logic                 calc_en,
    output logic [NUM_LANES-1:0] self_mask,
    output logic [WB_W-1:0]      wb_en,
    input  logic                 wb_ready,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          frame_ctr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELF_RD,
        S_ITR_RD,
        S_CALC,
        S_WB,
        S_DONE
    } state_e;

    localparam int             W1       = IDX_W + 1;
    localparam logic [W1-1:0]  LAST_ITR = W1'(NUM_BOIDS - 1);
    localparam logic [W1-1:0]  NB_EXT   = W1'(NUM_BOIDS);
    localparam logic [W1-1:0]  NL_EXT   = W1'(NUM_LANES);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     self_base_q, self_base_d;
    logic [IDX_W-1:0]     itr_q, itr_d;
    logic [15:0]          frame_ctr_q, frame_ctr_d;
    logic                 start_q;
    logic                 start_edge;
    logic                 itr_last;
    logic                 group_last;
    logic [W1-1:0]        next_base;
    logic [NUM_LANES-1:0] lane_hit;

    // One extra bit keeps self_base+NUM_LANES exact when it reaches NUM_BOIDS.
    assign start_edge = start & ~start_q;
    assign itr_last   = ({1'b0, itr_q} == LAST_ITR);
    assign next_base  = {1'b0, self_base_q} + NL_EXT;
    assign group_last = (next_base >= NB_EXT);

    always_comb begin
        lane_hit = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_hit[k] = ({1'b0, itr_q} == ({1'b0, self_base_q} + W1'(k)));
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        self_base_d = self_base_q;
        itr_d       = itr_q;
        frame_ctr_d = frame_ctr_q;
        mem_req     = 1'b0;
        mem_idx     = '0;
        r_en_tot    = 1'b0;
        r_en_itr    = 1'b0;
        calc_en     = 1'b0;
        self_mask   = '0;
        wb_en       = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    self_base_d = '0;
                    itr_d       = '0;
                    state_d     = S_SELF_RD;
                end
            end
            S_SELF_RD: begin
                mem_req = 1'b1;
                mem_idx = self_base_q;
                if (mem_valid) begin
                    r_en_tot = 1'b1;
                    state_d  = S_ITR_RD;
                end
            end
            S_ITR_RD: begin
                mem_req = 1'b1;
                mem_idx = itr_q;
                if (mem_valid) begin
                    r_en_itr = 1'b1;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                calc_en   = 1'b1;
                self_mask = lane_hit;
                if (itr_last) begin
                    state_d = S_WB;
                end else begin
                    itr_d   = itr_q + IDX_W'(1);
                    state_d = S_ITR_RD;
                end
            end
            S_WB: begin
                wb_en = WB_MASK;
                if (wb_ready) begin
                    itr_d = '0;
                    if (group_last) begin
                        state_d = S_DONE;
                    end else begin
                        self_base_d = next_base[IDX_W-1:0];
                        state_d     = S_SELF_RD;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                frame_ctr_d = frame_ctr_q + 16'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous and clears every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            self_base_q <= '0;
            itr_q       <= '0;
            frame_ctr_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            self_base_q <= self_base_d;
            itr_q       <= itr_d;
            frame_ctr_q <= frame_ctr_d;
            start_q     <= start;
        end
    end

    assign self_base = self_base_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_ctr = frame_ctr_q;

endmodule

// File: tb/tb_boid_xcel_seq.sv
// Bench for boid_xcel_seq: three configurations (4x2, 8x8, 8x1) checked against a
// transaction-level expected-event queue plus a pair scoreboard and hand-derived timing.
module tb_boid_xcel_seq;

    typedef enum logic [3:0] {
        EV_NONE, EV_SELF, EV_ITR, EV_CALC, EV_WB, EV_DONE, EV_BAD
    } ev_kind_e;

    typedef struct packed {
        ev_kind_e    kind;
        logic [3:0]  dut;
        logic [7:0]  idx;
        logic [7:0]  base;
        logic [7:0]  mask;
    } ev_t;

    typedef struct packed {
        logic        mem_req;
        logic [2:0]  mem_idx;
        logic [2:0]  self_base;
        logic        r_en_tot;
        logic        r_en_itr;
        logic        calc_en;
        logic [7:0]  self_mask;
        logic [6:0]  wb_en;
        logic        busy;
        logic        done;
        logic [15:0] frame_ctr;
    } sig_t;

    logic       clk;
    logic       reset;
    logic [2:0] start_v;
    logic [2:0] mem_valid_v;
    logic [2:0] wb_ready_v;

    logic d0_req, d0_tot, d0_itr, d0_calc, d0_busy, d0_done;
    logic [1:0] d0_idx, d0_base, d0_mask;
    logic [6:0] d0_wb;
    logic [15:0] d0_fc;
    logic d1_req, d1_tot, d1_itr, d1_calc, d1_busy, d1_done;
    logic [2:0] d1_idx, d1_base;
    logic [7:0] d1_mask;
    logic [6:0] d1_wb;
    logic [15:0] d1_fc;
    logic d2_req, d2_tot, d2_itr, d2_calc, d2_busy, d2_done;
    logic [2:0] d2_idx, d2_base;
    logic [0:0] d2_mask;
    logic [6:0] d2_wb;
    logic [15:0] d2_fc;

    boid_xcel_seq #(.NUM_BOIDS(4), .NUM_LANES(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .mem_req(d0_req), .mem_idx(d0_idx),
        .mem_valid(mem_valid_v[0]), .self_base(d0_base), .r_en_tot(d0_tot), .r_en_itr(d0_itr),
        .calc_en(d0_calc), .self_mask(d0_mask), .wb_en(d0_wb), .wb_ready(wb_ready_v[0]),
        .busy(d0_busy), .done(d0_done), .frame_ctr(d0_fc));

    boid_xcel_seq #(.NUM_BOIDS(8), .NUM_LANES(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .mem_req(d1_req), .mem_idx(d1_idx),
        .mem_valid(mem_valid_v[1]), .self_base(d1_base), .r_en_tot(d1_tot), .r_en_itr(d1_itr),
        .calc_en(d1_calc), .self_mask(d1_mask), .wb_en(d1_wb), .wb_ready(wb_ready_v[1]),
        .busy(d1_busy), .done(d1_done), .frame_ctr(d1_fc));

    boid_xcel_seq #(.NUM_BOIDS(8), .NUM_LANES(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .mem_req(d2_req), .mem_idx(d2_idx),
        .mem_valid(mem_valid_v[2]), .self_base(d2_base), .r_en_tot(d2_tot), .r_en_itr(d2_itr),
        .calc_en(d2_calc), .self_mask(d2_mask), .wb_en(d2_wb), .wb_ready(wb_ready_v[2]),
        .busy(d2_busy), .done(d2_done), .frame_ctr(d2_fc));

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   cmp_en   = 0;
    ev_t  exp_q[$];
    int   mem_wait[3]  = '{default: 0};
    int   wb_wait[3]   = '{default: 0};
    int   mcnt[3]      = '{default: 0};
    int   wcnt[3]      = '{default: 0};
    int   first_req[3] = '{default: -1};
    int   t_launch[3]  = '{default: 0};
    int   done_cyc[3]  = '{default: 0};
    int   done_cnt[3]  = '{default: 0};
    int   last_itr[3]  = '{default: 0};
    int   n_tot[3]     = '{default: 0};
    int   n_itr[3]     = '{default: 0};
    int   n_calc[3]    = '{default: 0};
    int   n_wbcyc[3]   = '{default: 0};
    int   pair_cnt[3][8][8];
    logic [7:0] mask_log[8][8];

    function automatic int nb(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int nl(input int d);
        case (d)
            0:       return 2;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic sig_t outs(input int d);
        sig_t s;
        case (d)
            0: s = {d0_req, 1'b0, d0_idx, 1'b0, d0_base, d0_tot, d0_itr, d0_calc, 6'b0, d0_mask,
                    d0_wb, d0_busy, d0_done, d0_fc};
            1: s = {d1_req, d1_idx, d1_base, d1_tot, d1_itr, d1_calc, d1_mask,
                    d1_wb, d1_busy, d1_done, d1_fc};
            default: s = {d2_req, d2_idx, d2_base, d2_tot, d2_itr, d2_calc, 7'b0, d2_mask,
                          d2_wb, d2_busy, d2_done, d2_fc};
        endcase
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected transaction order for one frame: every group reads its self boids,
    // then each neighbour read is followed by one accumulate, then one write-back.
    task automatic build_frame(input int d);
        ev_t e;
        for (int b = 0; b < nb(d); b += nl(d)) begin
            e = '0; e.dut = 4'(d); e.kind = EV_SELF; e.idx = 8'(b); e.base = 8'(b);
            exp_q.push_back(e);
            for (int n = 0; n < nb(d); n++) begin
                e = '0; e.dut = 4'(d); e.kind = EV_ITR; e.idx = 8'(n); e.base = 8'(b);
                exp_q.push_back(e);
                e.kind = EV_CALC;
                for (int k = 0; k < nl(d); k++) if (b + k == n) e.mask[k] = 1'b1;
                exp_q.push_back(e);
            end
            e = '0; e.dut = 4'(d); e.kind = EV_WB; e.base = 8'(b); e.mask = 8'h1f;
            exp_q.push_back(e);
        end
        e = '0; e.dut = 4'(d); e.kind = EV_DONE;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int d);
        sig_t s;
        ev_t  obs, exp_e;
        logic [7:0] bad;
        int sb;
        s = outs(d);
        bad = '0;
        bad[0] = !s.mem_req && (s.mem_idx != 0);
        bad[1] = !s.calc_en && (s.self_mask != 0);
        bad[2] = (s.wb_en != 0) && (s.wb_en != 7'h1f);
        bad[3] = (s.r_en_tot || s.r_en_itr) && !(s.mem_req && mem_valid_v[d]);
        bad[4] = s.r_en_tot && s.r_en_itr;
        bad[5] = s.calc_en && (s.mem_req || s.wb_en != 0 || s.done);
        bad[6] = s.done && (s.mem_req || s.wb_en != 0);
        bad[7] = !s.busy && (s.mem_req || s.calc_en || s.wb_en != 0 || s.done);
        check($sformatf("strobe_qual dut%0d", d), 64'(bad), 64'(0));

        obs = '0;
        obs.dut = 4'(d);
        if (s.mem_req && first_req[d] < 0) first_req[d] = cyc;
        if (s.wb_en != 0) n_wbcyc[d]++;
        if (s.mem_req && mem_valid_v[d]) begin
            if (s.r_en_tot && !s.r_en_itr) obs.kind = EV_SELF;
            else if (s.r_en_itr && !s.r_en_tot) obs.kind = EV_ITR;
            else obs.kind = EV_BAD;
            obs.idx  = 8'(s.mem_idx);
            obs.base = 8'(s.self_base);
            if (s.r_en_tot) n_tot[d]++;
            if (s.r_en_itr) begin
                n_itr[d]++;
                last_itr[d] = int'(s.mem_idx);
            end
        end else if (s.calc_en) begin
            obs.kind = EV_CALC;
            obs.idx  = 8'(last_itr[d]);
            obs.base = 8'(s.self_base);
            obs.mask = s.self_mask;
            n_calc[d]++;
            if (d == 0) mask_log[s.self_base][last_itr[d]] = s.self_mask;
            for (int k = 0; k < nl(d); k++) begin
                sb = int'(s.self_base) + k;
                if (sb < nb(d) && last_itr[d] < nb(d)) pair_cnt[d][sb][last_itr[d]]++;
            end
        end else if (s.wb_en != 0 && wb_ready_v[d]) begin
            obs.kind = EV_WB;
            obs.base = 8'(s.self_base);
            obs.mask = {1'b0, s.wb_en};
        end else if (s.done) begin
            obs.kind = EV_DONE;
            done_cyc[d] = cyc;
            done_cnt[d]++;
        end

        if (obs.kind != EV_NONE) begin
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_event dut%0d", d), 64'(obs), 64'(0));
            end else begin
                exp_e = exp_q.pop_front();
                check($sformatf("event dut%0d", d), 64'(obs), 64'(exp_e));
            end
        end
    endtask

    task automatic launch(input int d);
        build_frame(d);
        first_req[d] = -1;
        n_tot[d] = 0; n_itr[d] = 0; n_calc[d] = 0; n_wbcyc[d] = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                pair_cnt[d][i][j] = 0;
                if (d == 0) mask_log[i][j] = 8'hff;
            end
        @(negedge clk);
        start_v[d] = 1'b1;
        t_launch[d] = cyc;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic finish_frame(input int d, input int offset, input int fc);
        bit ok;
        int n0;
        int bad_pairs;
        ok = 0;
        n0 = done_cnt[d];
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #2;
            if (done_cnt[d] != n0) ok = 1;
        end
        check($sformatf("done_seen dut%0d", d), 64'(ok), 64'(1));
        check($sformatf("first_req_offset dut%0d", d), 64'(first_req[d] - t_launch[d]), 64'(1));
        check($sformatf("done_offset dut%0d", d), 64'(done_cyc[d] - t_launch[d]), 64'(offset));
        @(negedge clk); #2;
        check($sformatf("busy_after_done dut%0d", d), 64'(outs(d).busy), 64'(0));
        check($sformatf("frame_ctr dut%0d", d), 64'(outs(d).frame_ctr), 64'(fc));
        check($sformatf("queue_drained dut%0d", d), 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        bad_pairs = 0;
        for (int i = 0; i < nb(d); i++)
            for (int j = 0; j < nb(d); j++)
                if (pair_cnt[d][i][j] != 1) bad_pairs++;
        check($sformatf("pairs_once dut%0d", d), 64'(bad_pairs), 64'(0));
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory and write-back responders: zero-wait when the wait count is 0, else stall N cycles.
    initial begin
        sig_t s;
        mem_valid_v = '1;
        wb_ready_v  = '1;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                s = outs(d);
                if (mem_wait[d] == 0) mem_valid_v[d] = 1'b1;
                else if (s.mem_req) begin
                    if (mcnt[d] >= mem_wait[d]) begin mem_valid_v[d] = 1'b1; mcnt[d] = 0; end
                    else begin mem_valid_v[d] = 1'b0; mcnt[d]++; end
                end else mem_valid_v[d] = 1'b0;
                if (wb_wait[d] == 0) wb_ready_v[d] = 1'b1;
                else if (s.wb_en != 0) begin
                    if (wcnt[d] >= wb_wait[d]) begin wb_ready_v[d] = 1'b1; wcnt[d] = 0; end
                    else begin wb_ready_v[d] = 1'b0; wcnt[d]++; end
                end else wb_ready_v[d] = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (cmp_en) for (int d = 0; d < 3; d++) observe(d);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by time limit, want self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n0;
        reset   = 1'b1;
        start_v = '0;
        repeat (3) @(negedge clk);
        #2;
        for (int d = 0; d < 3; d++)
            check($sformatf("reset_outs dut%0d", d), 64'(outs(d)), 64'(0));
        cmp_en = 1;
        reset  = 1'b0;

        // Zero-wait frame: 2 groups x 10 cycles, DONE at c+21.
        launch(0);
        finish_frame(0, 21, 1);
        check("r_en_tot_count", 64'(n_tot[0]), 64'(2));
        check("r_en_itr_count", 64'(n_itr[0]), 64'(8));
        check("calc_en_count", 64'(n_calc[0]), 64'(8));
        check("wb_cycle_count", 64'(n_wbcyc[0]), 64'(2));
        check("mask g0 itr0", 64'(mask_log[0][0]), 64'(8'h01));
        check("mask g0 itr1", 64'(mask_log[0][1]), 64'(8'h02));
        check("mask g0 itr2", 64'(mask_log[0][2]), 64'(8'h00));
        check("mask g0 itr3", 64'(mask_log[0][3]), 64'(8'h00));
        check("mask g1 itr0", 64'(mask_log[2][0]), 64'(8'h00));
        check("mask g1 itr1", 64'(mask_log[2][1]), 64'(8'h00));
        check("mask g1 itr2", 64'(mask_log[2][2]), 64'(8'h01));
        check("mask g1 itr3", 64'(mask_log[2][3]), 64'(8'h02));

        // Stalled frame: 10 reads x 3 + 2 write-backs x 2 extra cycles.
        mem_wait[0] = 3; wb_wait[0] = 2; mcnt[0] = 0; wcnt[0] = 0;
        launch(0);
        finish_frame(0, 55, 2);
        check("stall r_en_itr_count", 64'(n_itr[0]), 64'(8));
        check("stall wb_cycle_count", 64'(n_wbcyc[0]), 64'(6));
        mem_wait[0] = 0; wb_wait[0] = 0;

        // Edge while busy is dropped; edge after done starts a new frame.
        launch(0);
        repeat (5) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        finish_frame(0, 21, 3);
        repeat (5) @(negedge clk);
        #2;
        check("idle_after_dropped_edge", 64'(outs(0).busy), 64'(0));
        launch(0);
        finish_frame(0, 21, 4);

        // Reset during a neighbour read of group 1 aborts the frame silently.
        launch(0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #2;
            if (outs(0).mem_req && outs(0).r_en_itr && outs(0).self_base == 3'd2) ok = 1;
        end
        check("reached_group1_itr", 64'(ok), 64'(1));
        reset = 1'b1;
        @(negedge clk); #2;
        check("abort_outs", 64'(outs(0)), 64'(0));
        exp_q.delete();
        reset = 1'b0;
        n0 = done_cnt[0];
        repeat (10) @(negedge clk);
        #2;
        check("no_done_after_abort", 64'(done_cnt[0] - n0), 64'(0));
        check("idle_after_abort", 64'(outs(0).busy), 64'(0));
        launch(0);
        finish_frame(0, 21, 1);

        // Wide and narrow lane configurations.
        launch(1);
        finish_frame(1, 19, 1);
        check("8x8 calc_en_count", 64'(n_calc[1]), 64'(8));
        launch(2);
        finish_frame(2, 145, 1);
        check("8x1 r_en_tot_count", 64'(n_tot[2]), 64'(8));
        check("8x1 calc_en_count", 64'(n_calc[2]), 64'(64));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
